// File: rtl/fir_pkg.sv
// fir_pkg: shared fixed-point helpers for the FIR blocks.
//   wide_t        - signed working width used for every intermediate product/sum
//   COEF_SHIFT    - product shift for the default Q1.7 coefficient format
//   coef_shift    - product shift for an arbitrary coefficient width
//   sat_to        - clamp a wide value to a signed N-bit range
//   sat_add       - saturating add, clamped to a signed N-bit range
//   mul_shift_sat - full-width multiply, floor shift, clamp to a signed N-bit range
package fir_pkg;

  // Wide enough for a product of two signed 16-bit operands plus headroom.
  localparam int WIDE_W              = 48;
  localparam int DEF_TAP_COEFF_WIDTH = 8;
  localparam int COEF_SHIFT          = DEF_TAP_COEFF_WIDTH - 1;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // Coefficients are Q1.(W-1), so a product is rescaled by W-1 bits.
  function automatic int coef_shift(input int coeff_width);
    return coeff_width - 1;
  endfunction

  function automatic wide_t sat_to(input wide_t v, input int width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (width - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int width);
    return sat_to(a + b, width);
  endfunction

  // >>> on a signed operand is an arithmetic shift, i.e. floor division.
  function automatic wide_t mul_shift_sat(input wide_t h, input wide_t w,
                                          input int shift, input int width);
    wide_t p;
    p = h * w;
    return sat_to(p >>> shift, width);
  endfunction

endpackage

// File: rtl/fir_sat_dot.sv
// fir_sat_dot: combinational saturating dot product of a sample window and
// a coefficient set.
//   window - samples, index 0 is the newest
//   coeffs - h[k], applied to window[k]
//   y      - saturated filter result
// Summation follows the transposed-chain order (oldest tap first) with a
// clamp after every addition, so results match the transposed FIR exactly,
// including when intermediate sums saturate.
module fir_sat_dot
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int TAP_COEFF_WIDTH = 8,
  parameter int NUM_TAPS        = 16
) (
  input  logic signed [DATA_WIDTH-1:0]      window [NUM_TAPS-1:0],
  input  logic signed [TAP_COEFF_WIDTH-1:0] coeffs [NUM_TAPS-1:0],
  output logic signed [DATA_WIDTH-1:0]      y
);

  localparam int SHIFT = coef_shift(TAP_COEFF_WIDTH);

  wide_t acc;

  always_comb begin
    acc = mul_shift_sat(wide_t'(coeffs[NUM_TAPS-1]), wide_t'(window[NUM_TAPS-1]),
                        SHIFT, DATA_WIDTH);
    for (int k = NUM_TAPS - 2; k >= 0; k--) begin
      acc = sat_add(mul_shift_sat(wide_t'(coeffs[k]), wide_t'(window[k]), SHIFT, DATA_WIDTH),
                    acc, DATA_WIDTH);
    end
    // acc is already clamped to the DATA_WIDTH range, so truncation is lossless.
    y = DATA_WIDTH'(acc);
  end

endmodule

// File: rtl/fir_decim.sv
// fir_decim: decimating FIR filter, one saturated output per DECIM accepted inputs.
//   clk, rst      - clock, asynchronous active-high reset
//   clear         - synchronous flush of history and phase (coefficients kept)
//   in_valid, in  - input sample handshake and data
//   coeff_load    - capture tap_coeffs into the coefficient registers
//   tap_coeffs    - h[k], k=0 applied to the newest sample
//   out_valid     - one-cycle pulse marking a new out
//   out           - registered decimated sample
//   phase         - samples accepted since the last output
module fir_decim
  import fir_pkg::*;
#(
  parameter  int DATA_WIDTH      = 8,
  parameter  int TAP_COEFF_WIDTH = 8,
  parameter  int NUM_TAPS        = 16,
  parameter  int DECIM           = 4,
  localparam int PHASE_W         = (DECIM > 1) ? $clog2(DECIM) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              in_valid,
  input  logic signed [DATA_WIDTH-1:0]      in,
  input  logic                              coeff_load,
  input  logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS-1:0],
  output logic                              out_valid,
  output logic signed [DATA_WIDTH-1:0]      out,
  output logic [PHASE_W-1:0]                phase
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DECIM - 1);

  logic signed [DATA_WIDTH-1:0]      hist_p0   [NUM_TAPS-2:0];
  logic signed [TAP_COEFF_WIDTH-1:0] coeff_p0  [NUM_TAPS-1:0];
  logic signed [DATA_WIDTH-1:0]      window_p0 [NUM_TAPS-1:0];
  logic signed [DATA_WIDTH-1:0]      y_p0;
  logic [PHASE_W-1:0]                phase_p0;
  logic signed [DATA_WIDTH-1:0]      out_p1;
  logic                              vld_p1;
  logic                              accept;
  logic                              out_instant;

  // clear wins over a coincident in_valid: the sample is dropped.
  assign accept      = in_valid && !clear;
  assign out_instant = accept && (phase_p0 == LAST_PHASE);

  // ---- stage p0: window = {incoming sample, stored history} ----
  always_comb begin
    window_p0[0] = in;
    for (int k = 1; k < NUM_TAPS; k++) begin
      window_p0[k] = hist_p0[k-1];
    end
  end

  fir_sat_dot #(
    .DATA_WIDTH     (DATA_WIDTH),
    .TAP_COEFF_WIDTH(TAP_COEFF_WIDTH),
    .NUM_TAPS       (NUM_TAPS)
  ) u_dot (
    .window(window_p0),
    .coeffs(coeff_p0),
    .y     (y_p0)
  );

  // History and phase; both flushed by clear, held across in_valid gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS - 1; k++) hist_p0[k] <= '0;
      phase_p0 <= '0;
    end else if (clear) begin
      for (int k = 0; k < NUM_TAPS - 1; k++) hist_p0[k] <= '0;
      phase_p0 <= '0;
    end else if (in_valid) begin
      hist_p0[0] <= in;
      for (int k = 1; k < NUM_TAPS - 1; k++) hist_p0[k] <= hist_p0[k-1];
      phase_p0 <= (phase_p0 == LAST_PHASE) ? '0 : phase_p0 + PHASE_W'(1);
    end
  end

  // Coefficients load at the edge, so an output computed on that same edge
  // still sees the previous set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) coeff_p0[k] <= '0;
    end else if (coeff_load) begin
      coeff_p0 <= tap_coeffs;
    end
  end

  // ---- stage p1: registered output and its valid pulse ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= out_instant;
      if (out_instant) out_p1 <= y_p0;
    end
  end

  assign out       = out_p1;
  assign out_valid = vld_p1;
  assign phase     = phase_p0;

endmodule

// File: tb/tb_fir_decim.sv
// tb_fir_decim: directed, self-checking bench for fir_decim.
// A DECIM=2 instance is the main target; a DECIM=1 instance shares the same
// stimulus and is checked during the impulse sequence.
module tb_fir_decim;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in = '0;
  logic              coeff_load = 1'b0;
  logic signed [7:0] tap_coeffs [3:0];
  logic              out_valid, out_valid1;
  logic signed [7:0] out, out1;
  logic [0:0]        phase, phase1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int h0; int h1; int h2; int h3;
    int x;
    int y;
  } vec_t;
  vec_t vecs [7];

  fir_decim #(.DATA_WIDTH(8), .TAP_COEFF_WIDTH(8), .NUM_TAPS(4), .DECIM(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(in),
    .coeff_load(coeff_load), .tap_coeffs(tap_coeffs),
    .out_valid(out_valid), .out(out), .phase(phase)
  );

  fir_decim #(.DATA_WIDTH(8), .TAP_COEFF_WIDTH(8), .NUM_TAPS(4), .DECIM(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(in),
    .coeff_load(coeff_load), .tap_coeffs(tap_coeffs),
    .out_valid(out_valid1), .out(out1), .phase(phase1)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic set_h(input int a, input int b, input int c, input int d);
    tap_coeffs[0] = 8'(a);
    tap_coeffs[1] = 8'(b);
    tap_coeffs[2] = 8'(c);
    tap_coeffs[3] = 8'(d);
  endtask

  task automatic load_h(input int a, input int b, input int c, input int d);
    @(negedge clk);
    set_h(a, b, c, d);
    coeff_load = 1'b1;
    @(posedge clk); #1;
    coeff_load = 1'b0;
  endtask

  task automatic push(input int x);
    @(negedge clk);
    in_valid = 1'b1;
    in = 8'(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    int exp_imp2 [3];
    int exp_imp1 [6];
    exp_imp2 = '{25, 6, 0};
    exp_imp1 = '{50, 25, 12, 6, 0, 0};

    // Saturation and chain-order vectors: 4 constant samples, check 2nd output.
    vecs[0] = '{127, 127, 127, 127, 127, 127};
    vecs[1] = '{127, 127, 127, 127, -128, -128};
    vecs[2] = '{64, 0, 0, 0, -1, -1};
    vecs[3] = '{64, 64, 0, 0, 100, 100};
    vecs[4] = '{-128, 0, 0, 0, -128, 127};
    vecs[5] = '{127, 127, -128, -128, 127, 124};
    vecs[6] = '{-128, -128, 127, 127, 127, -127};

    set_h(0, 0, 0, 0);

    // Reset state
    #2;
    check("reset_out", out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_phase", phase, 0);
    check("reset_out1", out1, 0);
    @(negedge clk);
    rst = 1'b0;

    // Impulse, continuous in_valid
    load_h(64, 32, 16, 8);
    for (int k = 0; k < 6; k++) begin
      push(k == 0 ? 100 : 0);
      check($sformatf("imp_vld[%0d]", k), out_valid, k % 2);
      check($sformatf("imp_phase[%0d]", k), phase, (k + 1) % 2);
      if (k % 2 == 1) check($sformatf("imp_out[%0d]", k), out, exp_imp2[k / 2]);
      check($sformatf("d1_vld[%0d]", k), out_valid1, 1);
      check($sformatf("d1_out[%0d]", k), out1, exp_imp1[k]);
      check($sformatf("d1_phase[%0d]", k), phase1, 0);
    end

    // Impulse with 3 idle cycles between samples
    do_clear();
    for (int k = 0; k < 6; k++) begin
      push(k == 0 ? 100 : 0);
      check($sformatf("gap_vld[%0d]", k), out_valid, k % 2);
      if (k % 2 == 1) check($sformatf("gap_out[%0d]", k), out, exp_imp2[k / 2]);
      repeat (3) begin
        @(posedge clk); #1;
        check($sformatf("gap_idle_vld[%0d]", k), out_valid, 0);
      end
      check($sformatf("gap_idle_phase[%0d]", k), phase, (k + 1) % 2);
    end

    // Clear colliding with in_valid at phase 1
    do_clear();
    push(100);
    push(0);
    check("clr_pre_out", out, 25);
    push(100);
    check("clr_pre_phase", phase, 1);
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    in = 8'sd50;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_phase", phase, 0);
    check("clr_vld", out_valid, 0);
    check("clr_out_hold", out, 25);
    push(10);
    check("clr_next_vld0", out_valid, 0);
    push(20);
    check("clr_next_vld1", out_valid, 1);
    check("clr_next_out", out, 12);

    // Coefficient swap on an output-instant accept
    do_clear();
    push(100);
    @(negedge clk);
    in_valid = 1'b1;
    in = 8'sd0;
    set_h(0, 0, 0, 64);
    coeff_load = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    coeff_load = 1'b0;
    check("swap_vld", out_valid, 1);
    check("swap_old_out", out, 25);
    push(0);
    push(0);
    check("swap_new_vld", out_valid, 1);
    check("swap_new_out", out, 50);

    // Asynchronous reset mid-stream
    load_h(64, 32, 16, 8);
    do_clear();
    push(100);
    push(0);
    push(50);
    check("arst_pre_out", out, 25);
    check("arst_pre_phase", phase, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out", out, 0);
    check("arst_vld", out_valid, 0);
    check("arst_phase", phase, 0);
    @(negedge clk);
    rst = 1'b0;
    load_h(64, 32, 16, 8);
    push(100);
    check("arst_first_vld0", out_valid, 0);
    check("arst_first_phase", phase, 1);
    push(0);
    check("arst_first_vld1", out_valid, 1);
    check("arst_first_out", out, 25);

    // Table-driven saturation vectors
    for (int v = 0; v < 7; v++) begin
      do_clear();
      load_h(vecs[v].h0, vecs[v].h1, vecs[v].h2, vecs[v].h3);
      for (int k = 0; k < 4; k++) push(vecs[v].x);
      check($sformatf("vec%0d_vld", v), out_valid, 1);
      check($sformatf("vec%0d_out", v), out, vecs[v].y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_decim.md
Name: fir_decim

Overview:
- Decimating FIR filter, the counterpart to the interpolation path's transposed FIR.
- Accepts one input sample per `in_valid` cycle and keeps a NUM_TAPS-deep sample history.
- Emits one filtered, saturated sample for every DECIM accepted inputs.
- Sits in the return (downsampling) path of the interpolation filter chain; uses the same signed fixed-point data and coefficient formats as the FIR blocks.

Parameters:
- DATA_WIDTH, 8: signed sample width, in and out.
- TAP_COEFF_WIDTH, 8: signed coefficient width; coefficients are Q1.(TAP_COEFF_WIDTH-1).
- NUM_TAPS, 16: filter length; must be >= 2.
- DECIM, 4: decimation factor; must be >= 1.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- clear, input, 1: synchronous flush of history and phase; coefficients are kept.
- in_valid, input, 1: `in` is accepted this cycle.
- in, input, DATA_WIDTH signed: input sample.
- coeff_load, input, 1: capture `tap_coeffs` into the coefficient registers this cycle.
- tap_coeffs, input, TAP_COEFF_WIDTH signed x [NUM_TAPS-1:0]: h[k], where k=0 is applied to the newest sample.
- out_valid, output, 1: single-cycle pulse marking a new `out`.
- out, output, DATA_WIDTH signed: decimated filtered sample, registered.
- phase, output, $clog2(DECIM) (min 1): number of samples accepted since the last output.

Behaviour:
- Reset (async, immediate): history x[0..NUM_TAPS-2], coefficient registers, phase, out and out_valid all become 0.
- Accept: on a cycle with in_valid=1 and clear=0:
  - x[0] <= in; x[k] <= x[k-1].
  - phase increments, wrapping from DECIM-1 to 0.
- Output instant: an accept with phase==DECIM-1 (every accept when DECIM=1).
  - At that edge, out <= y, where y is computed from the window {in, x[0..NUM_TAPS-2]} and the current coefficient registers.
  - out_valid=1 in the following cycle only.
  - Latency: 1 clock from the edge accepting the DECIM-th sample.
  - The first output after reset or clear uses the DECIM-th accepted sample; earlier history taps are 0.
- Non-output cycles: out holds its value; out_valid=0.
- Arithmetic:
  - Product p[k] = (h[k]*w[k]) at full width, then arithmetic shift right by TAP_COEFF_WIDTH-1 (floor), then saturate to DATA_WIDTH.
  - Accumulation runs in transposed-chain order: s = p[NUM_TAPS-1]; for k = NUM_TAPS-2 down to 0, s = sat(p[k] + s).
  - Saturation clamps each step to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - y = s.
- clear=1 (synchronous):
  - History and phase go to 0; out_valid next cycle is 0; out holds its value.
  - If in_valid is asserted in the same cycle, that sample is dropped (clear wins).
- coeff_load:
  - The coefficient registers load at the edge.
  - An output computed at that same edge uses the old coefficients.
- in_valid gaps: no state change; phase and history hold indefinitely.
- Reset mid-operation: the partial phase is discarded; output cadence restarts from phase 0.

Decomposition:
- Package fir_pkg holds:
  - sat_add and mul_shift_sat functions, parameterised via localparams.
  - The shift constant TAP_COEFF_WIDTH-1.
- One sub-module, fir_sat_dot: combinational window x coefficients -> y, using the chain order above.
- fir_decim owns the history registers, coefficient registers, phase counter, output register and valid logic.

Test Plan:
All tests use DATA_WIDTH=8, TAP_COEFF_WIDTH=8, NUM_TAPS=4, DECIM=2, unless stated.
- Impulse:
  - Stimulus: load coeffs h=[64,32,16,8]; apply continuous in_valid with in = 100, then zeros.
  - Response: out_valid pulses after accepted samples 1, 3 and 5 (0-based), with out = 25, 6, 0.
  - phase toggles 1, 0, 1, ...
- Saturation:
  - Stimulus: h all 127, in constant 127 → out = 127.
  - Stimulus: h all 127, in constant -128 → out = -128.
  - Stimulus: h[0]=64, others 0, in = -1 → out = -1 (floor).
- Gapped valid:
  - Stimulus: impulse test with in_valid low for 3 cycles between each pair of samples.
  - Response: identical out sequence; out_valid occurs only the cycle after an output-instant accept.
- Clear and collision:
  - Stimulus: assert clear together with in_valid in mid-stream (phase=1).
  - Response: sample dropped; phase=0; history zeroed; next output occurs after 2 further accepts and reflects only those samples.
- Coefficient swap:
  - Stimulus: assert coeff_load on an output-instant accept.
  - Response: that output uses the old h; the next output uses the new h.
- Async reset:
  - Stimulus: assert rst mid-cycle while phase=1 and out is nonzero.
  - Response: out, out_valid and phase are 0 immediately; after release, the first output follows the 2nd accepted sample.
  - Repeat the impulse test with DECIM=1 → out_valid on every accept, out = 50, 25, 12, 6, 0.
